// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the execute-stage multiply/divide unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_ITER  = DEF_WIDTH;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } muldiv_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: per-lane for operands and quotient/remainder,
// or across {a,b} as one double-width value for products.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             neg_a,
    input  logic             neg_b,
    input  logic             wide,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);
    logic [2*WIDTH-1:0] joint;

    assign joint = neg_a ? -{a, b} : {a, b};

    always_comb begin
        out_a = neg_a ? -a : a;
        out_b = neg_b ? -b : b;
        if (wide) begin
            {out_a, out_b} = joint;
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit holding HI/LO; one shift-add or restoring step per cycle.
// Define MULDIV_EARLY_OUT_EN to let multiplies stop once the remaining multiplier is zero.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ITER  = WIDTH
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    muldiv_state_e      state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               neg_hi_reg;
    logic               neg_lo_reg;
    logic               wide_reg;
    logic               dz_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               neg_rs;
    logic               neg_rt;
    logic [WIDTH-1:0]   mag_rs;
    logic [WIDTH-1:0]   mag_rt;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic               last_step;
    logic               mul_exit;

    assign neg_rs = op_is_signed(bus.op) & bus.rs_data[WIDTH-1];
    assign neg_rt = op_is_signed(bus.op) & bus.rt_data[WIDTH-1];

    muldiv_signfix #(.WIDTH(WIDTH)) u_opnd_fix (
        .a(bus.rs_data), .b(bus.rt_data), .neg_a(neg_rs), .neg_b(neg_rt),
        .wide(1'b0), .out_a(mag_rs), .out_b(mag_rt)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_res_fix (
        .a(acc_reg[2*WIDTH-1:WIDTH]), .b(acc_reg[WIDTH-1:0]),
        .neg_a(neg_hi_reg), .neg_b(neg_lo_reg),
        .wide(wide_reg), .out_a(res_hi), .out_b(res_lo)
    );

    // Multiply: multiplicand shifts left so the product is aligned at any exit point.
    assign mul_sum   = acc_reg + (b_reg[0] ? mcand_reg : '0);
    // Divide: acc holds {remainder, dividend bits still to be shifted in / quotient bits}.
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};
    assign last_step = (cnt_reg == CNT_W'(ITER - 1));
    assign mul_exit  = last_step || (EARLY_OUT && ((b_reg >> 1) == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            b_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            neg_hi_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            wide_reg   <= 1'b0;
            dz_reg     <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        b_reg    <= mag_rt;
                        if (op_is_div(bus.op)) begin
                            mcand_reg <= '0;
                            wide_reg  <= 1'b0;
                            state_reg <= ST_DIV;
                            if (bus.rt_data == '0) begin
                                // Result preloaded; the DIV cycle only passes it through.
                                acc_reg    <= {bus.rs_data, {WIDTH{1'b1}}};
                                neg_hi_reg <= 1'b0;
                                neg_lo_reg <= 1'b0;
                                dz_reg     <= 1'b1;
                            end else begin
                                acc_reg    <= {{WIDTH{1'b0}}, mag_rs};
                                neg_hi_reg <= neg_rs;
                                neg_lo_reg <= neg_rs ^ neg_rt;
                                dz_reg     <= 1'b0;
                            end
                        end else begin
                            acc_reg    <= '0;
                            mcand_reg  <= {{WIDTH{1'b0}}, mag_rs};
                            neg_hi_reg <= neg_rs ^ neg_rt;
                            neg_lo_reg <= neg_rs ^ neg_rt;
                            wide_reg   <= 1'b1;
                            dz_reg     <= 1'b0;
                            state_reg  <= (EARLY_OUT && (mag_rt == '0)) ? ST_FIX : ST_MUL;
                        end
                    end else if (!bus.start && !bus.flush) begin
                        if (bus.hi_we) hi_reg <= bus.wdata;
                        if (bus.lo_we) lo_reg <= bus.wdata;
                    end
                end
                ST_MUL: begin
                    if (bus.flush) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg   <= mul_sum;
                        mcand_reg <= mcand_reg << 1;
                        b_reg     <= b_reg >> 1;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        if (mul_exit) state_reg <= ST_FIX;
                    end
                end
                ST_DIV: begin
                    if (bus.flush) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (dz_reg) begin
                        state_reg <= ST_FIX;
                    end else begin
                        acc_reg <= div_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (last_step) state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!bus.flush) begin
                        hi_reg   <= res_hi;
                        lo_reg   <= res_lo;
                        done_reg <= 1'b1;
                    end
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: arithmetic/latency reference model checked every cycle,
// plus literal expectations per transaction.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_muldiv_if #(.WIDTH(W)) bus ();

    ex_muldiv #(.WIDTH(W), .ITER(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    int           m_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an operation, from plain integer arithmetic.
    function automatic void model_result(input logic [1:0] o, input logic [W-1:0] a, b,
                                         output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint     sa, sb, sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (o)
            OP_MULT: begin
                sp = sa * sb;
                {hi, lo} = sp;
            end
            OP_MULTU: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            default: begin
                if (b == '0) begin
                    lo = '1;
                    hi = a;
                end else if (o == OP_DIV) begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Edges after the start edge until HI/LO are written.
    function automatic int model_latency(input logic [1:0] o, input logic [W-1:0] b);
        logic [W-1:0] mag;
        int           steps;
        if (o == OP_DIV || o == OP_DIVU) return (b == '0) ? 2 : W + 1;
        if (!EO) return W + 1;
        mag   = (o == OP_MULT && b[W-1]) ? -b : b;
        steps = 0;
        for (int i = 0; i < W; i++) if (mag[i]) steps = i + 1;
        return steps + 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus.start && !bus.flush) begin
                    model_result(bus.op, bus.rs_data, bus.rt_data, p_hi, p_lo);
                    m_left = model_latency(bus.op, bus.rt_data);
                    m_busy = 1'b1;
                end else if (!bus.start && !bus.flush) begin
                    if (bus.hi_we) m_hi = bus.wdata;
                    if (bus.lo_we) m_lo = bus.wdata;
                end
            end else if (bus.flush) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cyc_busy", bus.busy, m_busy);
            chk("cyc_done", bus.done, m_done);
            chk("cyc_hi", bus.hi, m_hi);
            chk("cyc_lo", bus.lo, m_lo);
        end
    end

    task automatic drive(input logic s, input logic [1:0] o, input logic [W-1:0] a, b,
                         input logic f, hw, lw, input logic [W-1:0] wd);
        @(negedge clk);
        bus.start   = s;
        bus.op      = o;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.flush   = f;
        bus.hi_we   = hw;
        bus.lo_we   = lw;
        bus.wdata   = wd;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, b,
                          input logic lw, input logic [W-1:0] wd,
                          input logic [W-1:0] ehi, elo, input int elat);
        int lat = 0;
        drive(1'b1, o, a, b, 1'b0, 1'b0, lw, wd);
        idle();
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) break;
        end
        chk({name, "_lat"}, 64'(lat), 64'(elat));
        chk({name, "_hi"}, bus.hi, ehi);
        chk({name, "_lo"}, bus.lo, elo);
        $display("txn %s op=%0d rs=%h rt=%h -> hi=%h lo=%h latency=%0d",
                 name, o, a, b, bus.hi, bus.lo, lat);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
    endtask

    initial begin
        int pulses;
        bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset: hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

        // MTHI / MTLO, then a MULTU flushed at edge N+10 with a stray start at N+3
        drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b0, 32'hAAAA);
        drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b1, 32'h1234);
        idle();
        chk("mthi", bus.hi, 32'hAAAA);
        chk("mtlo", bus.lo, 32'h1234);
        drive(1'b1, OP_MULTU, 32'd3, 32'd3, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 10; k++) begin
            drive(k == 3, OP_DIVU, 32'd9, 32'd0, k == 10, 1'b0, 1'b0, '0);
        end
        @(posedge clk);
        #1;
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_hi", bus.hi, 32'hAAAA);
        chk("flush_lo", bus.lo, 32'h1234);
        idle();
        count_done(40, pulses);
        chk("flush_no_done", 64'(pulses), 64'd0);
        $display("txn flush MULTU at N+10: busy=%b hi=%h lo=%h done_pulses=%0d",
                 bus.busy, bus.hi, bus.lo, pulses);

        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, '0,
               32'hFFFFFFFF, 32'hFFFFFFEB, EO ? 4 : 33);
        run_op("mult_neg_rt", OP_MULT, 32'd7, 32'hFFFFFFFD, 1'b0, '0,
               32'hFFFFFFFF, 32'hFFFFFFEB, EO ? 3 : 33);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 1'b0, '0, 32'd2, 32'd14, 33);
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, '0,
               32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run_op("div_negneg", OP_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, '0,
               32'hFFFFFFFF, 32'd3, 33);
        run_op("div_zero", OP_DIV, 32'd5, 32'd0, 1'b0, '0, 32'd5, 32'hFFFFFFFF, 2);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, '0,
               32'h0, 32'h80000000, 33);
        run_op("divu_max", OP_DIVU, 32'hFFFFFFFF, 32'd1, 1'b0, '0, 32'h0, 32'hFFFFFFFF, 33);
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0,
               32'hFFFFFFFE, 32'h00000001, 33);
        run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 1'b0, '0,
               32'h40000000, 32'h0, 33);
        run_op("mult_zero", OP_MULT, 32'h12345678, 32'd0, 1'b0, '0, 32'h0, 32'h0, EO ? 1 : 33);
        // MTLO in the same cycle as start is dropped; the multiply still runs
        run_op("multu_mtlo", OP_MULTU, 32'd5, 32'd3, 1'b1, 32'h5555, 32'h0, 32'd15, EO ? 3 : 33);

        // Flush landing on the FIX edge
        drive(1'b1, OP_DIVU, 32'd100, 32'd3, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 33; k++) begin
            drive(1'b0, 2'b00, '0, '0, k == 33, 1'b0, 1'b0, '0);
        end
        @(posedge clk);
        #1;
        chk("fixflush_busy", bus.busy, 1'b0);
        chk("fixflush_lo", bus.lo, 32'd15);
        idle();
        count_done(5, pulses);
        chk("fixflush_no_done", 64'(pulses), 64'd0);
        $display("txn flush at FIX: busy=%b hi=%h lo=%h done_pulses=%0d",
                 bus.busy, bus.hi, bus.lo, pulses);

        // Reset at edge N+5 of a divide
        drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 4; k++) idle();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        count_done(40, pulses);
        chk("midrst_no_done", 64'(pulses), 64'd0);
        $display("txn reset mid-DIVU: busy=%b hi=%h lo=%h done_pulses=%0d",
                 bus.busy, bus.hi, bus.lo, pulses);

        // MTHI+MTLO together, then start+flush in IDLE (start ignored)
        drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, 1'b1, 32'h77);
        drive(1'b1, OP_MULTU, 32'd2, 32'd2, 1'b1, 1'b0, 1'b0, '0);
        idle();
        chk("both_we_hi", bus.hi, 32'h77);
        chk("both_we_lo", bus.lo, 32'h77);
        chk("startflush_busy", bus.busy, 1'b0);
        count_done(40, pulses);
        chk("startflush_no_done", 64'(pulses), 64'd0);
        $display("txn MTHI+MTLO then start+flush: hi=%h lo=%h busy=%b",
                 bus.hi, bus.lo, bus.busy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
